// File: rtl/lock_pkg.sv
// lock_pkg: definitions shared by the lock code enrollment block and the lock
// FSM that reads the committed code.
//   - FSM state encodings (also shown on the debug LEDs)
//   - code geometry (presses, switch count, index width, timeout)
//   - DEFAULT_CODE, the code published out of reset
//   - slot_get / slot_set helpers for the packed index vector
package lock_pkg;

  localparam int CODE_LEN_DEF    = 4;
  localparam int NSW_DEF         = 8;
  localparam int IDX_W           = 3;   // 2**IDX_W must cover every switch
  localparam int TIMEOUT_CYC_DEF = 10;
  localparam int CODE_W          = CODE_LEN_DEF * IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  typedef logic [CODE_W-1:0] code_t;

  // Slot 0 (first press) sits in the low bits: slots read {0,1,2,3}.
  localparam code_t DEFAULT_CODE = {3'd3, 3'd2, 3'd1, 3'd0};

  function automatic logic [IDX_W-1:0] slot_get(input code_t code, input int unsigned slot);
    return code[slot*IDX_W +: IDX_W];
  endfunction

  function automatic code_t slot_set(input code_t code, input int unsigned slot,
                                     input logic [IDX_W-1:0] idx);
    code_t r;
    r = code;
    r[slot*IDX_W +: IDX_W] = idx;
    return r;
  endfunction

endpackage

// File: rtl/rise_detect_vec.sv
// rise_detect_vec: registered rising-edge detector across a switch bank.
// Ports:
//   clk        in   clock, rising edge
//   clear      in   asynchronous active-low reset
//   sw         in   NSW switch levels, synchronous to clk
//   rise_any   out  at least one switch rose (as of the previous edge)
//   rise_multi out  two or more switches rose together
//   rise_idx   out  index of the risen switch (meaningful when exactly one rose)
module rise_detect_vec #(
  parameter int NSW   = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [NSW-1:0]   sw,
  output logic             rise_any,
  output logic             rise_multi,
  output logic [IDX_W-1:0] rise_idx
);

  logic [NSW-1:0] prev_q;
  logic [NSW-1:0] rise_q;

  // prev_q follows the level every cycle regardless of what the consumer is
  // doing, so a switch held across an idle period never shows up as a rise.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= sw;
      rise_q <= sw & ~prev_q;
    end
  end

  assign rise_any   = |rise_q;
  // Clearing the lowest set bit leaves something only if more than one bit is set.
  assign rise_multi = |(rise_q & (rise_q - NSW'(1)));

  // One-hot to index: OR together the index of every set bit.
  logic [IDX_W-1:0] idx_terms [NSW];

  generate
    for (genvar gi = 0; gi < NSW; gi++) begin : g_idx
      assign idx_terms[gi] = rise_q[gi] ? IDX_W'(gi) : '0;
    end
  endgenerate

  always_comb begin
    rise_idx = '0;
    for (int i = 0; i < NSW; i++) begin
      rise_idx = rise_idx | idx_terms[i];
    end
  end

endmodule

// File: rtl/lock_code_enroll.sv
// lock_code_enroll: captures a new unlock code from the switch bank, optionally
// asks for it a second time, and publishes it to the lock FSM.
// Build option: define LOCK_ENROLL_CONFIRM_EN to require the confirm pass;
// without it CAPTURE commits directly after the last press.
// Ports:
//   clk        in   clock, rising edge
//   clear      in   asynchronous active-low reset
//   sw         in   NSW switch levels, synchronous to clk
//   enroll     in   enrollment request level (rising edge starts enrollment)
//   code_out   out  committed code, slot i at [i*IDX_W +: IDX_W]
//   code_valid out  set once any enrollment has committed
//   busy       out  CAPTURE or CONFIRM
//   done       out  one-cycle pulse on commit
//   error      out  one-cycle pulse on abort
//   state_out  out  current state code for debug LEDs
module lock_code_enroll
  import lock_pkg::*;
#(
  parameter int NSW         = NSW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [NSW-1:0]    sw,
  input  logic              enroll,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_out
);

  // Code length is fixed by the package because the lock FSM shares the layout.
  localparam int CODE_LEN = CODE_LEN_DEF;
  localparam int CNT_W    = $clog2(CODE_LEN);
  localparam int TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic             rise_any;
  logic             rise_multi;
  logic [IDX_W-1:0] rise_idx;

  rise_detect_vec #(
    .NSW   (NSW),
    .IDX_W (IDX_W)
  ) u_rise (
    .clk        (clk),
    .clear      (clear),
    .sw         (sw),
    .rise_any   (rise_any),
    .rise_multi (rise_multi),
    .rise_idx   (rise_idx)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  code_t            shadow_q, shadow_d;
  code_t            code_q, code_d;
  logic             valid_q, valid_d;
  logic             enroll_prev_q, enroll_rise_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    valid_d  = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        // Switch rises are dropped here, including one coincident with enroll.
        if (enroll_rise_q) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end

      ST_CAPTURE: begin
        if (rise_multi) begin
          state_d = ST_ERROR;
        end else if (rise_any) begin
          // A press in the expiry cycle is checked first, so it beats the timeout.
          shadow_d = slot_set(shadow_q, 32'(cnt_q), rise_idx);
          tmr_d    = '0;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef LOCK_ENROLL_CONFIRM_EN
            state_d = ST_CONFIRM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

`ifdef LOCK_ENROLL_CONFIRM_EN
      ST_CONFIRM: begin
        if (rise_multi) begin
          state_d = ST_ERROR;
        end else if (rise_any) begin
          tmr_d = '0;
          if (rise_idx != slot_get(shadow_q, 32'(cnt_q))) begin
            state_d = ST_ERROR;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        shadow_d = '0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Publish on the edge that enters DONE so code_out and done line up.
    // shadow_d already holds the final press when confirm is compiled out.
    if (state_d == ST_DONE) begin
      code_d  = shadow_d;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      shadow_q      <= '0;
      code_q        <= DEFAULT_CODE;
      valid_q       <= 1'b0;
      enroll_prev_q <= 1'b0;
      enroll_rise_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      shadow_q      <= shadow_d;
      code_q        <= code_d;
      valid_q       <= valid_d;
      enroll_prev_q <= enroll;
      enroll_rise_q <= enroll & ~enroll_prev_q;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign busy       = (state_q == ST_CAPTURE) || (state_q == ST_CONFIRM);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign state_out  = state_q;

endmodule

// File: tb/tb_lock_code_enroll.sv
// tb_lock_code_enroll: table-driven enrollments plus hand-written corner
// sequences. Every done/error pulse is matched against a queue of expected
// outcomes pushed when the triggering stimulus is driven.
module tb_lock_code_enroll;
  import lock_pkg::*;

`ifdef LOCK_ENROLL_CONFIRM_EN
  localparam int NP = 8;
`else
  localparam int NP = 4;
`endif

  logic        clk    = 1'b0;
  logic        clear  = 1'b1;
  logic [7:0]  sw     = '0;
  logic        enroll = 1'b0;
  logic [11:0] code_out;
  logic        code_valid, busy, done, error;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  lock_code_enroll dut (
    .clk        (clk),
    .clear      (clear),
    .sw         (sw),
    .enroll     (enroll),
    .code_out   (code_out),
    .code_valid (code_valid),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .state_out  (state_out)
  );

  typedef struct {
    bit          is_done;
    logic [11:0] code;
    bit          valid;
  } exp_t;

  typedef struct {
    string name;
    int    press [8];
    int    ev_at;
    exp_t  exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  bit          seen_state2 = 1'b0;
  logic [11:0] mdl_code;
  bit          mdl_valid;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t mk(input string name, input int p0, input int p1, input int p2,
                              input int p3, input int p4, input int p5, input int p6,
                              input int p7, input int ev, input bit is_done,
                              input logic [11:0] code, input bit valid);
    vec_t v;
    v.name = name;
    v.press[0] = p0; v.press[1] = p1; v.press[2] = p2; v.press[3] = p3;
    v.press[4] = p4; v.press[5] = p5; v.press[6] = p6; v.press[7] = p7;
    v.ev_at = ev;
    v.exp.is_done = is_done;
    v.exp.code = code;
    v.exp.valid = valid;
    return v;
  endfunction

  // Scoreboard consumer: each pulse pops one expectation.
  always @(posedge clk) begin
    #2;
    if (state_out == 3'd2) seen_state2 = 1'b1;
    if (done || error) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual done=%0b error=%0b required no pulse", done, error);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse_done", 32'(done), 32'(mon_e.is_done));
        chk("pulse_error", 32'(error), 32'(!mon_e.is_done));
        chk("pulse_code_out", 32'(code_out), 32'(mon_e.code));
        chk("pulse_code_valid", 32'(code_valid), 32'(mon_e.valid));
        $display("txn %s code_out=%03h code_valid=%0b", done ? "done" : "error", code_out, code_valid);
      end
    end
  end

  task automatic enroll_pulse();
    enroll = 1'b1;
    @(negedge clk);
    enroll = 1'b0;
    @(negedge clk);
  endtask

  // One press: level high for one cycle, low for one. When ev is set the
  // outcome must appear exactly one edge after the rise is registered.
  task automatic do_press(input int idx, input bit ev, input exp_t e);
    if (ev) sb_q.push_back(e);
    sw = 8'(1 << idx);
    @(negedge clk);
    if (ev) chk("no_early_pulse", 32'(done | error), 32'd0);
    sw = '0;
    @(negedge clk);
    if (ev) chk("pulse_latency", 32'(sb_q.size()), 32'd0);
  endtask

  // Called right after a press: ten silent cycles must abort, not nine.
  task automatic timeout_expect(input string tag);
    exp_t e;
    e.is_done = 1'b0;
    e.code = mdl_code;
    e.valid = mdl_valid;
    sb_q.push_back(e);
    repeat (9) @(negedge clk);
    chk({tag, "_not_yet"}, 32'(sb_q.size()), 32'd1);
    @(negedge clk);
    chk({tag, "_fired"}, 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle"}, 32'(state_out), 32'(ST_IDLE));
  endtask

  initial begin
    vec_t tbl [4];
    exp_t e;

`ifdef LOCK_ENROLL_CONFIRM_EN
    tbl[0] = mk("mismatch_last", 1, 1, 3, 4, 1, 1, 3, 6, 7, 1'b0, DEFAULT_CODE, 1'b0);
    tbl[1] = mk("commit_5270", 5, 2, 7, 0, 5, 2, 7, 0, 7, 1'b1, pack4(5, 2, 7, 0), 1'b1);
    tbl[2] = mk("mismatch_second", 6, 5, 4, 3, 6, 1, 4, 3, 5, 1'b0, pack4(5, 2, 7, 0), 1'b1);
    tbl[3] = mk("commit_7777", 7, 7, 7, 7, 7, 7, 7, 7, 7, 1'b1, pack4(7, 7, 7, 7), 1'b1);
`else
    tbl[0] = mk("commit_6543", 6, 5, 4, 3, 0, 0, 0, 0, 3, 1'b1, pack4(6, 5, 4, 3), 1'b1);
    tbl[1] = mk("commit_5270", 5, 2, 7, 0, 0, 0, 0, 0, 3, 1'b1, pack4(5, 2, 7, 0), 1'b1);
    tbl[2] = mk("commit_7777", 7, 7, 7, 7, 0, 0, 0, 0, 3, 1'b1, pack4(7, 7, 7, 7), 1'b1);
    tbl[3] = mk("commit_4061", 4, 0, 6, 1, 0, 0, 0, 0, 3, 1'b1, pack4(4, 0, 6, 1), 1'b1);
`endif

    // Reset values
    #1 clear = 1'b0;
    #1;
    chk("rst_code_out", 32'(code_out), 32'(pack4(0, 1, 2, 3)));
    chk("rst_code_valid", 32'(code_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    mdl_code = pack4(0, 1, 2, 3);
    mdl_valid = 1'b0;

    // Table-driven enrollments
    for (int t = 0; t < 4; t++) begin
      enroll_pulse();
      chk({tbl[t].name, "_start"}, 32'(state_out), 32'(ST_CAPTURE));
      for (int k = 0; k < NP; k++) begin
        do_press(tbl[t].press[k], k == tbl[t].ev_at, tbl[t].exp);
      end
      @(negedge clk);
      chk({tbl[t].name, "_idle"}, 32'(state_out), 32'(ST_IDLE));
      chk({tbl[t].name, "_code_hold"}, 32'(code_out), 32'(tbl[t].exp.code));
      mdl_code = tbl[t].exp.code;
      mdl_valid = tbl[t].exp.valid;
    end

    e.is_done = 1'b0;
    e.code = mdl_code;
    e.valid = mdl_valid;

    // Press in the expiry cycle is accepted and restarts the timer
    enroll_pulse();
    do_press(3, 1'b0, e);
    repeat (8) @(negedge clk);
    do_press(4, 1'b0, e);
    timeout_expect("restart");

    // Plain timeout after one press
    enroll_pulse();
    do_press(3, 1'b0, e);
    timeout_expect("timeout");

    // Two switches rising together
    enroll_pulse();
    do_press(1, 1'b0, e);
    sb_q.push_back(e);
    sw = 8'h44;
    @(negedge clk);
    chk("multi_no_early", 32'(error), 32'd0);
    sw = '0;
    @(negedge clk);
    chk("multi_fired", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    chk("multi_idle", 32'(state_out), 32'(ST_IDLE));

    // enroll and a switch rise together: switch dropped; enroll while busy ignored
    enroll = 1'b1;
    sw = 8'h20;
    @(negedge clk);
    enroll = 1'b0;
    sw = '0;
    @(negedge clk);
    chk("simul_capture", 32'(state_out), 32'(ST_CAPTURE));
    do_press(3, 1'b0, e);
    do_press(3, 1'b0, e);
    enroll_pulse();
    chk("enroll_busy_ignored", 32'(state_out), 32'(ST_CAPTURE));
    do_press(1, 1'b0, e);
    e.is_done = 1'b1;
    e.code = pack4(3, 3, 1, 7);
    e.valid = 1'b1;
`ifdef LOCK_ENROLL_CONFIRM_EN
    do_press(7, 1'b0, e);
    do_press(3, 1'b0, e);
    do_press(3, 1'b0, e);
    do_press(1, 1'b0, e);
`endif
    do_press(7, 1'b1, e);
    mdl_code = e.code;
    mdl_valid = 1'b1;
    @(negedge clk);

    // clear in the middle of an enrollment after a commit
    enroll_pulse();
    do_press(2, 1'b0, e);
    do_press(4, 1'b0, e);
`ifdef LOCK_ENROLL_CONFIRM_EN
    do_press(6, 1'b0, e);
    do_press(1, 1'b0, e);
    do_press(2, 1'b0, e);
    chk("clear_pre_state", 32'(state_out), 32'(ST_CONFIRM));
`else
    chk("clear_pre_state", 32'(state_out), 32'(ST_CAPTURE));
`endif
    clear = 1'b0;
    #1;
    chk("clear_code_out", 32'(code_out), 32'(pack4(0, 1, 2, 3)));
    chk("clear_code_valid", 32'(code_valid), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_done", 32'(done), 32'd0);
    chk("clear_error", 32'(error), 32'd0);
    chk("clear_state", 32'(state_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    @(negedge clk);

`ifdef LOCK_ENROLL_CONFIRM_EN
    chk("confirm_state_seen", 32'(seen_state2), 32'd1);
`else
    chk("state2_never_seen", 32'(seen_state2), 32'd0);
`endif
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_code_enroll.md
# lock_code_enroll

Code-enrollment block for the digital lock: captures a new unlock sequence from the eight user switches and publishes it as a packed index vector for the lock FSM to check against. It is the writer side of the lock code; the lock FSM is the reader. Sits between the switch bank and the lock FSM. It runs a capture / confirm / commit sequence with an inter-press timeout.

## Interface
- `CODE_LEN`, 4: number of presses in a code.
- `NSW`, 8: number of switches.
- `IDX_W`, 3: switch-index width; must satisfy 2^IDX_W >= NSW.
- `TIMEOUT_CYC`, 10: idle cycles allowed between presses.

- `clk`  in  1: single clock, rising edge.
- `clear`  in  1: reset, asynchronous, active-low.
- `sw`  in  NSW: raw switch levels, already synchronous to `clk`.
- `enroll`  in  1: enrollment request level; only its rising edge is used.
- `code_out`  out  CODE_LEN*IDX_W: committed code. Slot i is in bits [i*IDX_W +: IDX_W]; slot 0 is the first press.
- `code_valid`  out  1: high once any enrollment has committed.
- `busy`  out  1: high in CAPTURE and CONFIRM.
- `done`  out  1: one-cycle pulse on commit.
- `error`  out  1: one-cycle pulse on abort.
- `state_out`  out  3: current FSM state, for debug LEDs.

## Operation
- Rising-edge detection registers `sw` and `enroll` each cycle. A rise is level high now and low in the previous cycle.
- A cycle holding a switch rise is a valid press only if exactly one bit of `sw` rose. Two or more bits rising together is a multi-press.
- FSM states (encoding fixed): IDLE=0, CAPTURE=1, CONFIRM=2, DONE=3, ERROR=4.
- IDLE:
  - A rise on `enroll` moves to CAPTURE and clears the press counter and the timer.
  - Switch rises are ignored.
- CAPTURE:
  - Each valid press writes the switch index into `shadow[cnt]`, then increments `cnt` and clears the timer.
  - After press CODE_LEN, `cnt` returns to 0 and the FSM moves to CONFIRM.
- CONFIRM:
  - Each valid press is compared with `shadow[cnt]`.
  - A mismatch moves to ERROR.
  - A match on the final press moves to DONE.
- Any state that is busy moves to ERROR on a multi-press or on timer expiry.
- DONE lasts exactly one cycle:
  - `code_out` <= shadow and `code_valid` <= 1 on entry.
  - Returns to IDLE.
- ERROR lasts exactly one cycle:
  - `code_out` and `code_valid` are unchanged.
  - Shadow is cleared.
  - Returns to IDLE.
- Timer:
  - Counts every cycle in CAPTURE and CONFIRM.
  - Expires when it reaches TIMEOUT_CYC-1 with no press in that cycle.
  - Result: TIMEOUT_CYC silent cycles cause an abort.
- Outputs are decoded from state: `busy`=CAPTURE|CONFIRM, `done`=DONE, `error`=ERROR.
- Press counter is clog2(CODE_LEN) bits, with explicit wrap to 0 at CODE_LEN. Timer width is clog2(TIMEOUT_CYC).

## Timing
- Reset values:
  - state IDLE; `busy`, `done`, `error` = 0.
  - `code_valid` = 0.
  - `code_out` = DEFAULT_CODE, slots {0,1,2,3}.
  - Shadow, counter, timer and previous-level registers = 0.
- Press latency:
  - `sw` is sampled high at edge N with its previous level low.
  - The rise flag is registered at edge N.
  - The FSM acts at edge N+1.
- `done`/`code_out` latency: both update at edge N+1 after the last confirm press, and `done` is high for that one cycle.
- Simultaneous events:
  - A press in the timer-expiry cycle wins over the timeout.
  - An `enroll` rise while busy, in DONE, or in ERROR is ignored.
  - In IDLE, an `enroll` rise in the same cycle as a switch rise starts CAPTURE and drops the switch rise.
- Switches held through reset produce no rise on the first cycle that is busy, because the previous-level register tracks the level continuously.
- `clear` asserted mid-enrollment:
  - Immediate return to reset values.
  - `code_out` reverts to DEFAULT_CODE.

## Configuration
- `LOCK_ENROLL_CONFIRM_EN` defined: CONFIRM is required, as described above.
- Not defined:
  - CONFIRM is compiled out.
  - CAPTURE moves directly to DONE after press CODE_LEN.
  - State code 2 is unreachable.
  - `state_out` encoding is otherwise unchanged.

## Structure
- Shared package `lock_pkg` holds:
  - state enum and its encodings;
  - `IDX_W`;
  - DEFAULT_CODE constant;
  - slot extract/insert helper functions.
- One sub-module, `rise_detect_vec`. It is NSW wide, registered, and outputs `rise_any`, `rise_multi` and the one-hot-to-index `rise_idx`.

## Test plan
- Enroll 5,2,7,0 then confirm 5,2,7,0:
  - `done` pulses one cycle after the final press;
  - `code_out` slots = {5,2,7,0};
  - `code_valid`=1.
- Enroll 1,1,3,4, confirm 1,1,3,6:
  - `error` pulses on the 4th confirm press;
  - `code_out` stays at DEFAULT {0,1,2,3}.
- Press 3 then wait 10 cycles:
  - `error` pulses;
  - FSM returns to IDLE; `busy`=0.
- Press at cycle 9 of the timer instead: accepted, and the timer restarts.
- Raise sw2 and sw6 in the same cycle during CAPTURE: `error` pulses and code is unchanged.
- Assert `clear` low mid-CONFIRM after a previous commit:
  - all outputs return to reset values;
  - `code_out` = {0,1,2,3}; `code_valid`=0.
- With `LOCK_ENROLL_CONFIRM_EN` undefined, enroll 6,5,4,3: `done` pulses one cycle after the 4th press, and state 2 is never seen.
